pinwheel_regfile_port: RTL and testbench

PINWHEEL_REGFILE_PORT -- requirements
Module: pinwheel_regfile_port

---
 rtl/pinwheel_pkg.sv | 18 +
 rtl/pinwheel_regfile_port.sv | 130 +++++++++++++
 tb/tb_pinwheel_regfile_port.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pinwheel_pkg.sv
// Shared widths, state encoding and address helpers for the pinwheel regfile port.
package pinwheel_pkg;

    localparam int REGFILE_ADDR_W = 8;
    localparam int REGFILE_DATA_W = 32;
    localparam int REG_IDX_W      = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regport_state_t;

    // Register index 0 of every hart is hard-wired to zero.
    function automatic logic is_reg_zero(input logic [REGFILE_ADDR_W-1:0] addr);
        return addr[REG_IDX_W-1:0] == '0;
    endfunction

endpackage

// File: rtl/pinwheel_regfile_port.sv
// Operand-read / writeback port in front of an external 256x32 multi-hart regfile:
// post-reset clearing, x0 masking and one-cycle write-to-read bypass.
//
// state | meaning
// CLEAR | sweep all 256 entries to zero, upstream held off (ready=0)
// RUN   | forward reads/writes, bypass same-cycle writeback into operands
module pinwheel_regfile_port
    import pinwheel_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rs_valid,
    input  logic [REGFILE_ADDR_W-1:0] rs1_addr,
    input  logic [REGFILE_ADDR_W-1:0] rs2_addr,
    input  logic                      wb_valid,
    input  logic [REGFILE_ADDR_W-1:0] wb_addr,
    input  logic [REGFILE_DATA_W-1:0] wb_data,
    output logic [REGFILE_ADDR_W-1:0] rf_raddr0,
    output logic [REGFILE_ADDR_W-1:0] rf_raddr1,
    input  logic [REGFILE_DATA_W-1:0] rf_rdata0,
    input  logic [REGFILE_DATA_W-1:0] rf_rdata1,
    output logic [REGFILE_ADDR_W-1:0] rf_waddr,
    output logic [REGFILE_DATA_W-1:0] rf_wdata,
    output logic                      rf_wren,
    output logic [REGFILE_DATA_W-1:0] rs1_data,
    output logic [REGFILE_DATA_W-1:0] rs2_data,
    output logic                      rs_data_valid,
    output logic                      ready
);

    localparam regport_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    localparam logic [REGFILE_ADDR_W-1:0] CNT_LAST = '1;

    regport_state_t state_q, state_d;
    logic [REGFILE_ADDR_W-1:0] clr_cnt_q;

    logic                      rd_pend_q;
    logic                      rs1_zero_q, rs2_zero_q;
    logic                      rs1_hit_q, rs2_hit_q;
    logic [REGFILE_DATA_W-1:0] byp_data_q;
    logic [REGFILE_DATA_W-1:0] rs1_hold_q, rs2_hold_q;
    logic [REGFILE_DATA_W-1:0] rs1_sel, rs2_sel;

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        rf_wren   = 1'b0;
        rf_waddr  = wb_addr;
        rf_wdata  = wb_data;
        rf_raddr0 = rs1_addr;
        rf_raddr1 = rs2_addr;
        case (state_q)
            CLEAR: begin
                rf_wren  = 1'b1;
                rf_waddr = clr_cnt_q;
                rf_wdata = '0;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ready   = 1'b1;
                rf_wren = wb_valid && !is_reg_zero(wb_addr);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR && clr_cnt_q != CNT_LAST) begin
                clr_cnt_q <= clr_cnt_q + REGFILE_ADDR_W'(1);
            end
        end
    end

    // Regfile is read-before-write, so a same-cycle writeback must be forwarded here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rs1_zero_q <= 1'b0;
            rs2_zero_q <= 1'b0;
            rs1_hit_q  <= 1'b0;
            rs2_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rd_pend_q  <= rs_valid && (state_q == RUN);
            rs1_zero_q <= is_reg_zero(rs1_addr);
            rs2_zero_q <= is_reg_zero(rs2_addr);
            rs1_hit_q  <= (state_q == RUN) && rf_wren && (rf_waddr == rs1_addr);
            rs2_hit_q  <= (state_q == RUN) && rf_wren && (rf_waddr == rs2_addr);
            byp_data_q <= wb_data;
        end
    end

    always_comb begin
        rs1_sel = rf_rdata0;
        rs2_sel = rf_rdata1;
        if (rs1_zero_q) begin
            rs1_sel = '0;
        end else if (rs1_hit_q) begin
            rs1_sel = byp_data_q;
        end
        if (rs2_zero_q) begin
            rs2_sel = '0;
        end else if (rs2_hit_q) begin
            rs2_sel = byp_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_hold_q <= '0;
            rs2_hold_q <= '0;
        end else if (rd_pend_q) begin
            rs1_hold_q <= rs1_sel;
            rs2_hold_q <= rs2_sel;
        end
    end

    assign rs_data_valid = rd_pend_q;
    assign rs1_data      = rd_pend_q ? rs1_sel : rs1_hold_q;
    assign rs2_data      = rd_pend_q ? rs2_sel : rs2_hold_q;

endmodule

// File: tb/tb_pinwheel_regfile_port.sv
// Directed bench for pinwheel_regfile_port with a read-before-write regfile model.
module tb_pinwheel_regfile_port;

    logic        clk;
    logic        rst_n;
    logic        rs_valid;
    logic [7:0]  rs1_addr, rs2_addr;
    logic        wb_valid;
    logic [7:0]  wb_addr;
    logic [31:0] wb_data;
    logic [7:0]  rf_raddr0, rf_raddr1, rf_waddr;
    logic [31:0] rf_rdata0, rf_rdata1, rf_wdata;
    logic        rf_wren;
    logic [31:0] rs1_data, rs2_data;
    logic        rs_data_valid, ready;

    logic        fill;
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [31:0] poke_data;
    logic [31:0] mem [256];

    int total;
    int passed;

    pinwheel_regfile_port #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs_valid      (rs_valid),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .rf_raddr0     (rf_raddr0),
        .rf_raddr1     (rf_raddr1),
        .rf_rdata0     (rf_rdata0),
        .rf_rdata1     (rf_rdata1),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_wren       (rf_wren),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .rs_data_valid (rs_data_valid),
        .ready         (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External regfile: registered read, old data returned on a same-address write.
    always @(posedge clk) begin
        rf_rdata0 <= mem[rf_raddr0];
        rf_rdata1 <= mem[rf_raddr1];
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (rf_wren) begin
            mem[rf_waddr] <= rf_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_clear(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk($sformatf("clear_%0d", i),
                {ready, rs_data_valid, rf_wren, rf_waddr, rf_wdata},
                {1'b0, 1'b0, 1'b1, 8'(i), 32'h0});
            @(negedge clk);
        end
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst_n     = 1'b0;
        rs_valid  = 1'b0;
        rs1_addr  = 8'h00;
        rs2_addr  = 8'h00;
        wb_valid  = 1'b0;
        wb_addr   = 8'h00;
        wb_data   = 32'h0;
        poke_en   = 1'b0;
        poke_addr = 8'h00;
        poke_data = 32'h0;
        fill      = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        #1;
        chk("rst_flags", {ready, rs_data_valid}, 2'b00);
        chk("rst_rs1", rs1_data, 32'h0);
        chk("rst_rs2", rs2_data, 32'h0);
        chk("rst_waddr", {rf_wren, rf_waddr}, {1'b1, 8'h00});
        @(negedge clk);

        // Clearing sweep with upstream traffic that must be ignored.
        rst_n    = 1'b1;
        wb_valid = 1'b1;
        wb_addr  = 8'h33;
        wb_data  = 32'hCAFE_F00D;
        rs_valid = 1'b1;
        rs1_addr = 8'h33;
        rs2_addr = 8'h34;
        check_clear(256);
        wb_valid = 1'b0;
        rs_valid = 1'b0;
        #1;
        chk("run_entry", {ready, rs_data_valid, rf_wren}, 3'b100);
        @(negedge clk);

        // Write then read next cycle from the regfile.
        wb_valid = 1'b1;
        wb_addr  = 8'h23;
        wb_data  = 32'hDEAD_BEEF;
        #1;
        chk("wb23_port", {rf_wren, rf_waddr, rf_wdata}, {1'b1, 8'h23, 32'hDEAD_BEEF});
        @(negedge clk);
        wb_valid = 1'b0;
        rs_valid = 1'b1;
        rs1_addr = 8'h23;
        rs2_addr = 8'h33;
        #1;
        chk("raddr", {rf_raddr0, rf_raddr1}, {8'h23, 8'h33});
        @(negedge clk);
        rs_valid = 1'b0;
        chk("rd23_valid", rs_data_valid, 1'b1);
        chk("rd23_rs1", rs1_data, 32'hDEAD_BEEF);
        chk("rd33_cleared", rs2_data, 32'h0);
        @(negedge clk);
        chk("hold_valid", rs_data_valid, 1'b0);
        chk("hold_rs1", rs1_data, 32'hDEAD_BEEF);

        // Same-cycle write and double read: both operands bypass.
        wb_valid = 1'b1;
        wb_addr  = 8'h45;
        wb_data  = 32'h1234_5678;
        rs_valid = 1'b1;
        rs1_addr = 8'h45;
        rs2_addr = 8'h45;
        @(negedge clk);
        wb_valid = 1'b0;
        rs_valid = 1'b0;
        chk("byp45_rs1", rs1_data, 32'h1234_5678);
        chk("byp45_rs2", rs2_data, 32'h1234_5678);

        // Seed reg-0 entries with junk so the forced-zero path is visible.
        poke_en   = 1'b1;
        poke_addr = 8'h40;
        poke_data = 32'h5555_AAAA;
        @(negedge clk);
        poke_addr = 8'h20;
        poke_data = 32'h0000_0077;
        @(negedge clk);
        poke_en = 1'b0;

        wb_valid = 1'b1;
        wb_addr  = 8'h40;
        wb_data  = 32'hFFFF_FFFF;
        rs_valid = 1'b1;
        rs1_addr = 8'h40;
        rs2_addr = 8'h20;
        #1;
        chk("wb40_blocked", rf_wren, 1'b0);
        @(negedge clk);
        wb_valid = 1'b0;
        rs_valid = 1'b0;
        chk("rd40_zero", rs1_data, 32'h0);
        chk("rd20_zero", rs2_data, 32'h0);

        // Same reg index, different hart: no bypass.
        wb_valid = 1'b1;
        wb_addr  = 8'h05;
        wb_data  = 32'h1111_1111;
        @(negedge clk);
        wb_addr  = 8'h25;
        wb_data  = 32'h0000_00AA;
        rs_valid = 1'b1;
        rs1_addr = 8'h05;
        rs2_addr = 8'h25;
        @(negedge clk);
        wb_valid = 1'b0;
        rs_valid = 1'b0;
        chk("hart_rs1", rs1_data, 32'h1111_1111);
        chk("hart_rs2_byp", rs2_data, 32'h0000_00AA);
        rs_valid = 1'b1;
        rs1_addr = 8'h25;
        rs2_addr = 8'h45;
        @(negedge clk);
        rs_valid = 1'b0;
        chk("rf_rs1_25", rs1_data, 32'h0000_00AA);
        chk("rf_rs2_45", rs2_data, 32'h1234_5678);

        // Reset in RUN with a read in flight.
        rs_valid = 1'b1;
        rs1_addr = 8'h23;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_run_flags", {ready, rs_data_valid}, 2'b00);
        chk("rst_run_rs1", rs1_data, 32'h0);
        @(negedge clk);
        rs_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("post_rst_valid", rs_data_valid, 1'b0);
        check_clear(100);

        // Reset at counter 100 restarts the sweep from 0.
        rst_n = 1'b0;
        #1;
        chk("mid_clear_rst", {ready, rf_wren, rf_waddr}, {1'b0, 1'b1, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        check_clear(256);
        #1;
        chk("run_again", ready, 1'b1);
        rs_valid = 1'b1;
        rs1_addr = 8'h23;
        rs2_addr = 8'h25;
        @(negedge clk);
        rs_valid = 1'b0;
        chk("recleared_rs1", rs1_data, 32'h0);
        chk("recleared_rs2", rs2_data, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
